// File: rtl/router_pkg.sv
// router_pkg: shared FSM state, header field helpers and pointer-width function for router_nport
package router_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int hdr_addr(input int hdr, input int addr_w);
        return hdr & ((1 << addr_w) - 1);
    endfunction

    function automatic int hdr_len(input int hdr, input int addr_w);
        return hdr >> addr_w;
    endfunction

endpackage

// File: rtl/router_chan_fifo.sv
// router_chan_fifo: per-channel FIFO with registered read and idle-timeout flush
module router_chan_fifo
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              vld,
    output logic              full
);
    localparam int AW = clog2(DEPTH);
    localparam int TW = clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_nxt;
    logic [TW-1:0]     timer;
    logic              wr, rd, flush;

    assign vld    = wr_ptr != rd_ptr;
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr     = we && !full;
    assign rd     = re && vld;
    assign wr_nxt = wr_ptr + (AW+1)'(wr);
    // flushing also discards a byte written on the same edge so vld_out really drops
    assign flush  = vld && !re && timer == TW'(TIMEOUT - 1);

    always_ff @(posedge clock)
        if (wr) mem[wr_ptr[AW-1:0]] <= din;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            timer  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= flush ? wr_nxt : rd_ptr + (AW+1)'(rd);
            timer  <= (vld && !re && !flush) ? timer + 1'b1 : '0;
            if (rd) dout <= mem[rd_ptr[AW-1:0]];
        end

endmodule

// File: rtl/router_nport.sv
// router_nport: N-channel byte-serial packet router; define ROUTER_ERR_CNT_EN to add err_count
module router_nport
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     pkt_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        vld_out,
    output logic                     err,
    output logic                     busy
`ifdef ROUTER_ERR_CNT_EN
    ,
    output logic [15:0]              err_count
`endif
);
    localparam int LEN_W = DATA_W - ADDR_W;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] dest, hdr_a;
    logic [LEN_W-1:0]  len, hdr_l;
    logic [DATA_W-1:0] par_acc, par_byte, pay_cnt;
    logic [NUM_CH-1:0] full, we;
    logic              hit, dfull, bad;

    assign hdr_a = ADDR_W'(hdr_addr(int'(data_in), ADDR_W));
    assign hdr_l = LEN_W'(hdr_len(int'(data_in), ADDR_W));
    assign hit   = int'(hdr_a) < NUM_CH;
    assign dfull = full[dest];
    assign bad   = par_acc != par_byte || pay_cnt != DATA_W'(len);

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pkt_valid) state_nxt = !hit ? DROP : full[hdr_a] ? IDLE : LOAD;
            LOAD:    if (!dfull && !pkt_valid) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            DROP:    if (!pkt_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state == CHECK || (state == LOAD && dfull) ||
               (state == IDLE && pkt_valid && hit && full[hdr_a]);
        we = '0;
        if (state == IDLE && pkt_valid && hit && !full[hdr_a]) we[hdr_a] = 1'b1;
        if (state == LOAD && !dfull) we[dest] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            dest     <= '0;
            len      <= '0;
            par_acc  <= '0;
            par_byte <= '0;
            pay_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pkt_valid && hit && !full[hdr_a]) begin
                    dest    <= hdr_a;
                    len     <= hdr_l;
                    par_acc <= data_in;
                    pay_cnt <= '0;
                    err     <= 1'b0;
                end
                LOAD: if (!dfull) begin
                    if (pkt_valid) begin
                        par_acc <= par_acc ^ data_in;
                        pay_cnt <= pay_cnt + 1'b1;
                    end else par_byte <= data_in;
                end
                CHECK: if (bad) err <= 1'b1;
                default: ;
            endcase
        end

`ifdef ROUTER_ERR_CNT_EN
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) err_count <= '0;
        else if (((state == IDLE && pkt_valid && !hit) || (state == CHECK && bad)) && err_count != 16'hFFFF)
            err_count <= err_count + 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH),
            .TIMEOUT(TIMEOUT)
        ) u_fifo (
            .clock (clock),
            .resetn(resetn),
            .we    (we[i]),
            .din   (data_in),
            .re    (read_enb[i]),
            .dout  (data_out[i*DATA_W +: DATA_W]),
            .vld   (vld_out[i]),
            .full  (full[i])
        );
    end

endmodule

// File: tb/tb_router_nport.sv
// tb_router_nport: randomized self-checking bench with a queue-based reference model
module tb_router_nport;
    localparam int NUM_CH  = 3;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;
    localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_DROP = 3;

    logic                clock, resetn, pkt_valid, err, busy;
    logic [7:0]          data_in;
    logic [NUM_CH-1:0]   read_enb, vld_out;
    logic [NUM_CH*8-1:0] data_out;
`ifdef ROUTER_ERR_CNT_EN
    logic [15:0]         err_count;
`endif

    router_nport dut (
        .clock    (clock),
        .resetn   (resetn),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .read_enb (read_enb),
        .data_out (data_out),
        .vld_out  (vld_out),
        .err      (err),
        .busy     (busy)
`ifdef ROUTER_ERR_CNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clock = ~clock;

    int         checks = 0, errors = 0, cyc = 0;
    logic [7:0] q [NUM_CH][$];
    logic [7:0] dexp [NUM_CH];
    int         idle [NUM_CH];
    logic       err_exp, last_busy, saw_busy;
    int         ecnt, phase, dest, len_m, cnt, rise0, fall0;
    logic [7:0] acc, pbyte;
    bit         s_pv [$];
    logic [7:0] s_d [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            q[i].delete();
            dexp[i] = '0;
            idle[i] = 0;
        end
        err_exp = 0; ecnt = 0; phase = P_IDLE; dest = 0; len_m = 0; cnt = 0; acc = '0; pbyte = '0;
        s_pv.delete();
        s_d.delete();
    endtask

    task automatic add_pkt(input int a, input int len, input int npay, input bit badpar);
        logic [5:0] l;
        logic [1:0] ad;
        logic [7:0] h, b, x;
        l = 6'(len);
        ad = 2'(a);
        h = {l, ad};
        x = h;
        s_pv.push_back(1); s_d.push_back(h);
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom);
            x ^= b;
            s_pv.push_back(1); s_d.push_back(b);
        end
        s_pv.push_back(0); s_d.push_back(badpar ? ~x : x);
    endtask

    task automatic model_edge(input bit pv, input logic [7:0] d, input logic [NUM_CH-1:0] rm);
        int pre [NUM_CH];
        int a, wr_ch;
        a = int'(d[1:0]);
        wr_ch = -1;
        for (int i = 0; i < NUM_CH; i++) pre[i] = q[i].size();
        case (phase)
            P_IDLE: if (pv) begin
                if (a >= NUM_CH) begin
                    phase = P_DROP;
                    if (ecnt < 16'hFFFF) ecnt++;
                end else if (pre[a] < DEPTH) begin
                    wr_ch = a; dest = a; len_m = int'(d[7:2]); acc = d; cnt = 0; err_exp = 0; phase = P_LOAD;
                end
            end
            P_LOAD: if (pre[dest] < DEPTH) begin
                wr_ch = dest;
                if (pv) begin acc ^= d; cnt++; end
                else begin pbyte = d; phase = P_CHECK; end
            end
            P_CHECK: begin
                if (acc != pbyte || cnt != len_m) begin
                    err_exp = 1;
                    if (ecnt < 16'hFFFF) ecnt++;
                end
                phase = P_IDLE;
            end
            default: if (!pv) phase = P_IDLE;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (rm[i] && pre[i] > 0) dexp[i] = q[i].pop_front();
            if (wr_ch == i) q[i].push_back(d);
            if (pre[i] > 0 && !rm[i]) begin
                idle[i]++;
                if (idle[i] == TIMEOUT) begin
                    q[i].delete();
                    idle[i] = 0;
                end
            end else idle[i] = 0;
        end
    endtask

    // called at a negedge; returns at the following negedge
    task automatic step(input logic [NUM_CH-1:0] rm);
        bit pv, bz;
        logic [7:0] d;
        int a;
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("vld%0d", i), vld_out[i], q[i].size() != 0);
            check($sformatf("dout%0d", i), data_out[i*8 +: 8], dexp[i]);
        end
        check("err", err, err_exp);
`ifdef ROUTER_ERR_CNT_EN
        check("err_count", err_count, ecnt);
`endif
        if (vld_out[0] && rise0 < 0) rise0 = cyc;
        if (!vld_out[0] && rise0 >= 0 && fall0 < 0) fall0 = cyc;
        pv = s_pv.size() != 0 ? s_pv[0] : 1'b0;
        d = s_d.size() != 0 ? s_d[0] : 8'($urandom);
        pkt_valid = pv; data_in = d; read_enb = rm;
        #1;
        a = int'(d[1:0]);
        bz = phase == P_CHECK || (phase == P_LOAD && q[dest].size() == DEPTH) ||
             (phase == P_IDLE && pv && a < NUM_CH && q[a].size() == DEPTH);
        check("busy", busy, bz);
        last_busy = busy;
        model_edge(pv, d, rm);
        if (!bz && s_pv.size() != 0) begin
            void'(s_pv.pop_front());
            void'(s_d.pop_front());
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic run(input logic [NUM_CH-1:0] m, input bit rnd);
        int n = 0;
        while ((s_pv.size() != 0 || phase != P_IDLE) && n < 3000) begin
            step(rnd ? m & 3'($urandom | $urandom) : m);
            n++;
        end
        check("drain", s_pv.size(), 0);
    endtask

    initial begin
        clock = 0; resetn = 0; pkt_valid = 0; data_in = '0; read_enb = '0;
        rise0 = -1; fall0 = -1; saw_busy = 0; last_busy = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("rst_vld", vld_out, 0);
        check("rst_dout", data_out, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        resetn = 1;
        @(negedge clock);

        add_pkt(0, 14, 14, 0);                 // header 0x38, fills ch0 exactly
        run(3'b000, 0);
        repeat (20) step(3'b001);

        add_pkt(1, 16, 16, 1);                 // bad parity, read ch1 only
        run(3'b010, 1);
        repeat (20) step(3'b111);

        add_pkt(2, 17, 17, 0);                 // overflows ch2 until read
        repeat (20) begin
            step(3'b000);
            saw_busy |= last_busy;
        end
        check("full_busy", saw_busy, 1);
        run(3'b100, 0);
        repeat (20) step(3'b111);

        add_pkt(3, 17, 17, 0);                 // header 0x47 is dropped
        run(3'b000, 0);
        add_pkt(1, 5, 7, 0);                   // length mismatch
        run(3'b010, 0);
        repeat (20) step(3'b111);

        rise0 = -1; fall0 = -1;
        add_pkt(0, 3, 3, 0);
        run(3'b000, 0);
        repeat (40) step(3'b000);
        check("timeout_cycles", fall0 - rise0, TIMEOUT);
        add_pkt(0, 4, 4, 0);
        run(3'b000, 0);
        repeat (20) step(3'b111);

        for (int k = 0; k < 40; k++) begin
            int a, l;
            a = $urandom_range(0, 3);
            l = $urandom_range(0, 20);
            add_pkt(a, l, l + ($urandom_range(0, 7) == 0 ? 1 : 0), $urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) begin
                s_pv.push_back(0); s_d.push_back(8'($urandom));
            end
            run(3'b111, 1);
        end
        repeat (20) step(3'b111);

        add_pkt(0, 10, 10, 0);                 // reset in mid-packet
        repeat (5) step(3'b000);
        pkt_valid = 0;
        resetn = 0;
        #1;
        check("midrst_vld", vld_out, 0);
        check("midrst_dout", data_out, 0);
        check("midrst_busy", busy, 0);
        model_reset();
        @(negedge clock);
        resetn = 1;
        @(negedge clock);
        add_pkt(0, 2, 2, 0);
        run(3'b000, 0);
        repeat (10) step(3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
